// File: rtl/exu_pkg.sv
// Shared constants and types for the integer execute stage.
package exu_pkg;

  // Major opcodes handled by the execute stage
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  // funct3 encodings of the integer ALU operations
  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SLT  = 3'b010;
  localparam logic [2:0] SLTU = 3'b011;
  localparam logic [2:0] XOR  = 3'b100;
  localparam logic [2:0] SR   = 3'b101;
  localparam logic [2:0] OR   = 3'b110;
  localparam logic [2:0] AND  = 3'b111;

  // funct7 encodings: base ops, alternate (SUB/SRA) and multiply group
  localparam logic [6:0] BASE   = 7'b0000000;
  localparam logic [6:0] ALT    = 7'b0100000;
  localparam logic [6:0] MULDIV = 7'b0000001;

  // Stage control states
  typedef enum logic {
    IDLE,
    MUL
  } state_t;

endpackage

// File: rtl/exu_stage_if.sv
// Handshake bundle between register-read, the execute stage and writeback.
interface exu_stage_if #(
  parameter int XLEN = 64
);

  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [11:0]     in_imm;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_illegal;

  // Environment side: issues instructions and consumes results
  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_src1, in_src2,
           in_imm, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_illegal
  );

  // Execute stage side
  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_src1, in_src2,
           in_imm, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_illegal
  );

endinterface

// File: rtl/exu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// In word mode only 32 iterations run and the product is the sign-extended
// low 32 bits. done is combinational during the final iteration so the
// caller can capture product on the same edge that completes it.
module exu_mul_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            word,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q;
  logic            word_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   last_cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc_next;

  assign last_cnt = word_q ? CW'(31) : CW'(XLEN - 1);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign busy     = busy_q;
  assign done     = busy_q && (cnt == last_cnt);
  assign product  = word_q ? XLEN'(signed'(acc_next[31:0])) : acc_next;

  // Load operands on start, then accumulate one partial product per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      word_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      word_q <= word;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= word ? XLEN'(a[31:0]) : a;
      mplier <= word ? XLEN'(b[31:0]) : b;
    end else if (busy_q) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exu_stage.sv
// Integer execute stage: decodes OP-IMM/OP/OP-IMM-32/OP-32, computes
// single-cycle results directly and hands MUL/MULW to the iterative
// multiplier. Results leave through a registered valid/ready slot.
module exu_stage
  import exu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input logic        clk,
  input logic        rst,
  exu_stage_if.slave bus
);

  state_t          state;
  logic            out_valid_q;
  logic [XLEN-1:0] out_data_q;
  logic [4:0]      out_rd_q;
  logic            out_ill_q;
  logic [4:0]      rd_hold;

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] imm_x;
  logic [5:0]      shamt_i;
  logic [5:0]      shamt_r;
  logic            sh_hi_ok;
  logic [XLEN-1:0] alu_res;
  logic [31:0]     w_res;
  logic            use_w;
  logic            dec_illegal;
  logic            dec_mul;
  logic            dec_word;

  logic            in_ready_c;
  logic            accept;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  assign src1     = bus.in_src1;
  assign src2     = bus.in_src2;
  assign imm_x    = XLEN'(signed'(bus.in_imm));
  assign shamt_i  = (XLEN == 64) ? bus.in_imm[5:0] : {1'b0, bus.in_imm[4:0]};
  assign shamt_r  = (XLEN == 64) ? src2[5:0] : {1'b0, src2[4:0]};
  assign sh_hi_ok = (XLEN == 64) || !bus.in_imm[5];

  assign in_ready_c = (state == IDLE) && !mul_busy && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign mul_start  = accept && dec_mul;

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_ill_q;

  // Decode the offered instruction and compute its single-cycle result
  always_comb begin
    alu_res     = '0;
    w_res       = '0;
    use_w       = 1'b0;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_word    = 1'b0;
    case (bus.in_opcode)
      OP_IMM: begin
        case (bus.in_funct3)
          ADD:  alu_res = src1 + imm_x;
          SLT:  alu_res = XLEN'($signed(src1) < $signed(imm_x));
          SLTU: alu_res = XLEN'(src1 < imm_x);
          XOR:  alu_res = src1 ^ imm_x;
          OR:   alu_res = src1 | imm_x;
          AND:  alu_res = src1 & imm_x;
          SLL: begin
            if (sh_hi_ok && bus.in_imm[11:6] == 6'b000000) alu_res = src1 << shamt_i;
            else dec_illegal = 1'b1;
          end
          SR: begin
            if (sh_hi_ok && bus.in_imm[11:6] == 6'b000000) alu_res = src1 >> shamt_i;
            else if (sh_hi_ok && bus.in_imm[11:6] == 6'b010000) alu_res = $signed(src1) >>> shamt_i;
            else dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP: begin
        if (bus.in_funct7 == BASE) begin
          case (bus.in_funct3)
            ADD:  alu_res = src1 + src2;
            SLL:  alu_res = src1 << shamt_r;
            SLT:  alu_res = XLEN'($signed(src1) < $signed(src2));
            SLTU: alu_res = XLEN'(src1 < src2);
            XOR:  alu_res = src1 ^ src2;
            SR:   alu_res = src1 >> shamt_r;
            OR:   alu_res = src1 | src2;
            AND:  alu_res = src1 & src2;
            default: dec_illegal = 1'b1;
          endcase
        end else if (bus.in_funct7 == ALT && bus.in_funct3 == ADD) begin
          alu_res = src1 - src2;
        end else if (bus.in_funct7 == ALT && bus.in_funct3 == SR) begin
          alu_res = $signed(src1) >>> shamt_r;
        end else if (MUL_EN && bus.in_funct7 == MULDIV && bus.in_funct3 == ADD) begin
          dec_mul = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_IMM_32: begin
        use_w = 1'b1;
        if (XLEN != 64) begin
          dec_illegal = 1'b1;
        end else begin
          case (bus.in_funct3)
            ADD: w_res = src1[31:0] + imm_x[31:0];
            SLL: begin
              if (bus.in_imm[11:5] == 7'b0000000) w_res = src1[31:0] << bus.in_imm[4:0];
              else dec_illegal = 1'b1;
            end
            SR: begin
              if (bus.in_imm[11:5] == 7'b0000000) w_res = src1[31:0] >> bus.in_imm[4:0];
              else if (bus.in_imm[11:5] == 7'b0100000) w_res = $signed(src1[31:0]) >>> bus.in_imm[4:0];
              else dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      OP_32: begin
        use_w = 1'b1;
        if (XLEN != 64) begin
          dec_illegal = 1'b1;
        end else if (bus.in_funct7 == BASE && bus.in_funct3 == ADD) begin
          w_res = src1[31:0] + src2[31:0];
        end else if (bus.in_funct7 == BASE && bus.in_funct3 == SLL) begin
          w_res = src1[31:0] << src2[4:0];
        end else if (bus.in_funct7 == BASE && bus.in_funct3 == SR) begin
          w_res = src1[31:0] >> src2[4:0];
        end else if (bus.in_funct7 == ALT && bus.in_funct3 == ADD) begin
          w_res = src1[31:0] - src2[31:0];
        end else if (bus.in_funct7 == ALT && bus.in_funct3 == SR) begin
          w_res = $signed(src1[31:0]) >>> src2[4:0];
        end else if (MUL_EN && bus.in_funct7 == MULDIV && bus.in_funct3 == ADD) begin
          dec_mul  = 1'b1;
          dec_word = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (use_w) begin
      alu_res = XLEN'(signed'(w_res));
    end
  end

  // Multiplier exists only when the MUL path is enabled
  generate
    if (MUL_EN) begin : g_mul
      exu_mul_iter #(
        .XLEN(XLEN)
      ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (src1),
        .b       (src2),
        .word    (dec_word),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      logic unused_mul;
      assign unused_mul  = mul_start ^ dec_word;
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Control FSM and registered output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_ill_q   <= 1'b0;
      rd_hold     <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_mul) begin
              state   <= MUL;
              rd_hold <= bus.in_rd;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= dec_illegal ? '0 : alu_res;
              out_rd_q    <= bus.in_rd;
              out_ill_q   <= dec_illegal;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mul_product;
            out_rd_q    <= rd_hold;
            out_ill_q   <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_stage.sv
// Self-checking bench for exu_stage: directed corner cases plus a
// randomized stream scored against a behavioural instruction model.
module tb_exu_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  rd;
    bit          ill;
  } exp_t;

  exp_t sb[$];

  exu_stage_if #(.XLEN(64)) bus ();
  exu_stage_if #(.XLEN(64)) bus0 ();

  exu_stage #(.XLEN(64), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exu_stage #(.XLEN(64), .MUL_EN(1'b0)) dut_nomul (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Architectural behaviour of each RV64I/M ALU instruction
  function automatic void ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [63:0] a,
                                    input logic [63:0] b, input logic [11:0] imm,
                                    output logic [63:0] d, output bit ill);
    logic [63:0] is;
    is  = {{52{imm[11]}}, imm};
    d   = 64'd0;
    ill = 1'b0;
    if (opc == 7'h13) begin
      case (f3)
        3'd0: d = a + is;
        3'd2: d = ($signed(a) < $signed(is)) ? 64'd1 : 64'd0;
        3'd3: d = (a < is) ? 64'd1 : 64'd0;
        3'd4: d = a ^ is;
        3'd6: d = a | is;
        3'd7: d = a & is;
        3'd1: if (imm[11:6] == 6'h00) d = a << imm[5:0]; else ill = 1'b1;
        default: begin
          if (imm[11:6] == 6'h00) d = a >> imm[5:0];
          else if (imm[11:6] == 6'h10) d = $signed(a) >>> imm[5:0];
          else ill = 1'b1;
        end
      endcase
    end else if (opc == 7'h33) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: d = a + b;
          3'd1: d = a << b[5:0];
          3'd2: d = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
          3'd3: d = (a < b) ? 64'd1 : 64'd0;
          3'd4: d = a ^ b;
          3'd5: d = a >> b[5:0];
          3'd6: d = a | b;
          default: d = a & b;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) d = a - b;
      else if (f7 == 7'h20 && f3 == 3'd5) d = $signed(a) >>> b[5:0];
      else if (f7 == 7'h01 && f3 == 3'd0) d = a * b;
      else ill = 1'b1;
    end else if (opc == 7'h1B) begin
      if (f3 == 3'd0) d = sx32(a[31:0] + is[31:0]);
      else if (f3 == 3'd1 && imm[11:5] == 7'h00) d = sx32(a[31:0] << imm[4:0]);
      else if (f3 == 3'd5 && imm[11:5] == 7'h00) d = sx32(a[31:0] >> imm[4:0]);
      else if (f3 == 3'd5 && imm[11:5] == 7'h20) d = sx32($signed(a[31:0]) >>> imm[4:0]);
      else ill = 1'b1;
    end else if (opc == 7'h3B) begin
      if (f7 == 7'h00 && f3 == 3'd0) d = sx32(a[31:0] + b[31:0]);
      else if (f7 == 7'h00 && f3 == 3'd1) d = sx32(a[31:0] << b[4:0]);
      else if (f7 == 7'h00 && f3 == 3'd5) d = sx32(a[31:0] >> b[4:0]);
      else if (f7 == 7'h20 && f3 == 3'd0) d = sx32(a[31:0] - b[31:0]);
      else if (f7 == 7'h20 && f3 == 3'd5) d = sx32($signed(a[31:0]) >>> b[4:0]);
      else if (f7 == 7'h01 && f3 == 3'd0) d = sx32(a[31:0] * b[31:0]);
      else ill = 1'b1;
    end else begin
      ill = 1'b1;
    end
    if (ill) d = 64'd0;
  endfunction

  task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [63:0] s1, input logic [63:0] s2,
                          input logic [11:0] imm, input logic [4:0] rd);
    bus.in_opcode = opc;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_src1   = s1;
    bus.in_src2   = s2;
    bus.in_imm    = imm;
    bus.in_rd     = rd;
    bus.in_valid  = 1'b1;
  endtask

  // Issue one single-cycle op with out_ready high and check its result
  task automatic apply_stimulus(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [63:0] s1, input logic [63:0] s2,
                                input logic [11:0] imm, input logic [4:0] rd,
                                input logic [63:0] exp_d, input bit exp_ill);
    drive_op(opc, f3, f7, s1, s2, imm, rd);
    bus.out_ready = 1'b1;
    #1;
    check_output({tag, "_in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_output({tag, "_valid"}, bus.out_valid, 1);
    check_output({tag, "_data"}, bus.out_data, exp_d);
    check_output({tag, "_rd"}, bus.out_rd, rd);
    check_output({tag, "_illegal"}, bus.out_illegal, exp_ill);
  endtask

  // Issue a MUL/MULW and measure the cycles until its result appears
  task automatic mul_latency(input string tag, input bit word, input logic [63:0] s1,
                             input logic [63:0] s2, input logic [63:0] exp_d, input int exp_lat);
    int  cycles;
    bit  ready_low;
    drive_op(word ? 7'h3B : 7'h33, 3'd0, 7'h01, s1, s2, 12'h000, 5'd9);
    bus.out_ready = 1'b1;
    #1;
    check_output({tag, "_in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    cycles    = 0;
    ready_low = 1'b1;
    while (!bus.out_valid && cycles < 200) begin
      if (bus.in_ready) ready_low = 1'b0;
      @(negedge clk);
      #1;
      cycles++;
    end
    check_output({tag, "_latency"}, cycles, exp_lat);
    check_output({tag, "_busy_ready_low"}, ready_low, 1);
    check_output({tag, "_data"}, bus.out_data, exp_d);
    check_output({tag, "_rd"}, bus.out_rd, 9);
    check_output({tag, "_illegal"}, bus.out_illegal, 0);
  endtask

  function automatic logic [63:0] rand_operand();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Present a fresh random instruction on the input port
  task automatic gen_random();
    int          r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    r   = $urandom_range(0, 99);
    f3  = 3'($urandom);
    imm = 12'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 2))
        0: imm[11:6] = 6'h00;
        1: imm[11:6] = 6'h10;
        default: imm[11:6] = 6'($urandom);
      endcase
    end
    if (r < 25) opc = 7'h13;
    else if (r < 50) opc = 7'h33;
    else if (r < 65) opc = 7'h1B;
    else if (r < 82) opc = 7'h3B;
    else if (r < 88) begin
      opc = ($urandom_range(0, 1) == 1) ? 7'h33 : 7'h3B;
      f3  = 3'd0;
      f7  = 7'h01;
    end else opc = 7'($urandom);
    drive_op(opc, f3, f7, rand_operand(), rand_operand(), imm, 5'($urandom));
  endtask

  // Compare the outgoing result against the oldest expected entry
  task automatic score_transfer(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_output({tag, "_unexpected_result"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_output({tag, "_data"}, bus.out_data, e.d);
      check_output({tag, "_rd"}, bus.out_rd, e.rd);
      check_output({tag, "_illegal"}, bus.out_illegal, e.ill);
    end
  endtask

  initial begin
    exp_t        e;
    logic [63:0] md;
    bit          mill;
    bit          pend;
    bit          saw_valid;
    int          budget;

    bus.in_valid   = 1'b0;
    bus.in_opcode  = '0;
    bus.in_funct3  = '0;
    bus.in_funct7  = '0;
    bus.in_src1    = '0;
    bus.in_src2    = '0;
    bus.in_imm     = '0;
    bus.in_rd      = '0;
    bus.out_ready  = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.in_opcode = '0;
    bus0.in_funct3 = '0;
    bus0.in_funct7 = '0;
    bus0.in_src1   = '0;
    bus0.in_src2   = '0;
    bus0.in_imm    = '0;
    bus0.in_rd     = '0;
    bus0.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset released");
    check_output("reset_out_valid", bus.out_valid, 0);
    check_output("reset_out_data", bus.out_data, 0);
    check_output("reset_out_rd", bus.out_rd, 0);
    check_output("reset_out_illegal", bus.out_illegal, 0);
    check_output("reset_in_ready", bus.in_ready, 1);

    apply_stimulus("addi", 7'h13, 3'd0, 7'h00, 64'd5, 64'd0, 12'hFFF, 5'd7, 64'd4, 1'b0);
    apply_stimulus("srai", 7'h13, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd0, 12'h403, 5'd3,
                   64'hF000_0000_0000_0000, 1'b0);
    apply_stimulus("sraiw", 7'h1B, 3'd5, 7'h20, 64'h0000_0000_8000_0000, 64'd0, 12'h404, 5'd4,
                   64'hFFFF_FFFF_F800_0000, 1'b0);
    apply_stimulus("addw", 7'h3B, 3'd0, 7'h00, 64'h0000_0000_7FFF_FFFF, 64'd1, 12'h000, 5'd5,
                   64'hFFFF_FFFF_8000_0000, 1'b0);
    apply_stimulus("sltu", 7'h33, 3'd3, 7'h00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 12'h000, 5'd6,
                   64'd1, 1'b0);
    apply_stimulus("slt", 7'h33, 3'd2, 7'h00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 12'h000, 5'd8,
                   64'd0, 1'b0);
    apply_stimulus("sub", 7'h33, 3'd0, 7'h20, 64'd3, 64'd5, 12'h000, 5'd10,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    apply_stimulus("lui_illegal", 7'h37, 3'd0, 7'h00, 64'd123, 64'd45, 12'h123, 5'd11,
                   64'd0, 1'b1);
    apply_stimulus("slli_illegal", 7'h13, 3'd1, 7'h00, 64'd1, 64'd0, 12'h041, 5'd12,
                   64'd0, 1'b1);
    apply_stimulus("slliw_imm5", 7'h1B, 3'd1, 7'h00, 64'd1, 64'd0, 12'h020, 5'd13,
                   64'd0, 1'b1);

    mul_latency("mul", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64);
    @(negedge clk);
    #1;
    check_output("mul_drained", bus.out_valid, 0);
    mul_latency("mulw", 1'b1, 64'h1234_5678_0001_0001, 64'hFFFF_FFFF_0001_0000,
                64'h0000_0000_0001_0000, 32);
    @(negedge clk);
    #1;

    drive_op(7'h33, 3'd0, 7'h01, 64'd7, 64'd6, 12'h000, 5'd14);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("mul_abort_valid", bus.out_valid, 0);
    check_output("mul_abort_data", bus.out_data, 0);
    check_output("mul_abort_rd", bus.out_rd, 0);
    check_output("mul_abort_in_ready", bus.in_ready, 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check_output("mul_abort_no_result", saw_valid, 0);

    bus0.in_opcode = 7'h33;
    bus0.in_funct3 = 3'd0;
    bus0.in_funct7 = 7'h01;
    bus0.in_src1   = 64'd9;
    bus0.in_src2   = 64'd9;
    bus0.in_rd     = 5'd15;
    bus0.in_valid  = 1'b1;
    #1;
    check_output("nomul_in_ready", bus0.in_ready, 1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    #1;
    check_output("nomul_valid", bus0.out_valid, 1);
    check_output("nomul_illegal", bus0.out_illegal, 1);
    check_output("nomul_data", bus0.out_data, 0);
    check_output("nomul_rd", bus0.out_rd, 15);

    bus.out_ready = 1'b0;
    drive_op(7'h33, 3'd0, 7'h00, 64'd10, 64'd20, 12'h000, 5'd4);
    @(negedge clk);
    #1;
    check_output("bp_first_valid", bus.out_valid, 1);
    check_output("bp_first_data", bus.out_data, 30);
    drive_op(7'h33, 3'd0, 7'h00, 64'd1, 64'd2, 12'h000, 5'd5);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("bp_hold_in_ready", bus.in_ready, 0);
      check_output("bp_hold_data", bus.out_data, 30);
      check_output("bp_hold_rd", bus.out_rd, 4);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check_output("bp_release_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_output("bp_second_valid", bus.out_valid, 1);
    check_output("bp_second_data", bus.out_data, 3);
    check_output("bp_second_rd", bus.out_rd, 5);
    @(negedge clk);
    #1;
    check_output("bp_drained", bus.out_valid, 0);

    $display("[TB] starting random stream");
    pend = 1'b0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (!pend) begin
        if ($urandom_range(0, 9) < 7) begin
          gen_random();
          pend = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) score_transfer("rand");
      if (bus.in_valid && bus.in_ready) begin
        ref_model(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_src1, bus.in_src2,
                  bus.in_imm, md, mill);
        e.d   = md;
        e.rd  = bus.in_rd;
        e.ill = mill;
        sb.push_back(e);
        pend = 1'b0;
      end
      @(negedge clk);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    budget = 0;
    #1;
    while (sb.size() > 0 && budget < 200) begin
      if (bus.out_valid) score_transfer("drain");
      @(negedge clk);
      #1;
      budget++;
    end
    check_output("drain_empty", sb.size(), 0);
    check_output("drain_idle_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_stage.md
# exu_stage

Parametrised integer execute stage for the NPC core: accepts one decoded RV64I/RV32I ALU instruction per handshake, computes the result, and returns it through a registered valid/ready output. Covers the full OP-IMM, OP, OP-IMM-32 and OP-32 groups and an optional iterative MUL/MULW path. Sits between the decode/register-read stage and writeback. Stalls upstream while a multiply iterates or the output slot is occupied.

## Interface
- XLEN, 64: datapath width, 32 or 64 only; the 32-bit (W) opcodes are legal only when 64.
- MUL_EN, 1: 1 enables MUL/MULW via the iterative multiplier; 0 flags them illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  7  instruction[6:0].
- in_funct3  in  3  instruction[14:12].
- in_funct7  in  7  instruction[31:25].
- in_src1, in_src2  in  XLEN  rs1 and rs2 operand values.
- in_imm  in  12  instruction[31:20], sign-extended internally.
- in_rd  in  5  destination register index, passed through.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  XLEN  result.
- out_rd  out  5  rd of the result.
- out_illegal  out  1  the instruction was unsupported; out_data = 0.

## Operation
- Accept when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Transfer out when out_valid && out_ready. Output registers hold while out_valid && !out_ready.
- Opcodes are 0010011 (OP-IMM), 0110011 (OP), 0011011 (OP-IMM-32) and 0111011 (OP-32). Every other opcode is illegal.
- OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Shift amount is imm[5:0] for XLEN=64 and imm[4:0] for XLEN=32.
  - imm[11:6] must be 000000 (SLLI, SRLI) or 010000 (SRAI). For XLEN=32, imm[5] must also be 0. Otherwise illegal.
- OP with funct7 0000000 or 0100000: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - 0100000 is legal only with funct3 000 or 101.
  - Shift amount is src2[log2(XLEN)-1:0].
- W forms: ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW.
  - Compute on the low 32 bits with a 5-bit shamt, then sign-extend bit 31 to 64.
  - For the immediate shifts, imm[5] = 1 is illegal.
- MUL (OP, funct7 0000001, funct3 000) returns the low XLEN bits of src1*src2. MULW returns sext(low32(src1[31:0]*src2[31:0])). Any other funct7 0000001 combination is illegal.
- Comparisons: SLT is signed and SLTU is unsigned; the result is 0 or 1, zero-extended.
- All add/sub arithmetic wraps modulo 2^XLEN (modulo 2^32 for W before extension).
- FSM:
  - IDLE: a single-cycle op or an illegal op loads the output registers and stays in IDLE. A MUL op loads the multiplier and moves to MUL.
  - MUL: shift-add, one bit per cycle, with the counter counting up to N (N = XLEN, or 32 for MULW). After iteration N the result is loaded into the output registers, out_valid is set and the FSM returns to IDLE.

## Timing
- Reset values: out_valid=0, out_data=0, out_rd=0, out_illegal=0, state=IDLE, counter=0, multiplier registers=0. in_ready is therefore 1 in the first cycle after reset.
- Single-cycle and illegal ops accepted at edge N show out_valid=1 after edge N.
- MUL accepted at edge N shows out_valid=1 after edge N+XLEN (N+32 for MULW). in_ready=0 throughout.
- Back-to-back: with out_ready held at 1, the stage accepts one single-cycle op per cycle at full throughput.
- Simultaneous output transfer and input accept in the same cycle: the output registers load the new result and out_valid stays 1.
- Output stalled while a new MUL is pending: acceptance is blocked by in_ready=0 until the transfer happens.
- rst mid-MUL aborts the multiply. No result is produced and everything returns to reset values on the next edge.
- out_illegal is valid only while out_valid is 1.

## Structure
- Package exu_pkg holds:
  - opcode constants: OP_IMM, OP, OP_IMM_32, OP_32;
  - funct3 constants: ADD, SLL, SLT, SLTU, XOR, SR, OR, AND;
  - funct7 constants: BASE=0000000, ALT=0100000, MULDIV=0000001;
  - the state enum {IDLE, MUL}.
- Sub-module exu_mul_iter (XLEN parameter): start, a, b, word mode → busy, done, product. It is instantiated only when MUL_EN=1 (generate).

## Test plan
- Reset then ADDI with src1=5 and imm=0xFFF → out_data=4 one cycle after accept, out_rd echoed, in_ready=1 throughout.
- SRAI with src1=0x8000_0000_0000_0000 and imm=0x403 (shamt 3) → 0xF000_0000_0000_0000. SRAIW with src1=0x0000_0000_8000_0000 and shamt 4 → 0xFFFF_FFFF_F800_0000.
- ADDW with src1=0x7FFF_FFFF and src2=1 → 0xFFFF_FFFF_8000_0000. SLTU with src1=1 and src2=0xFFFF…FFFF → 1. SLT with the same operands → 0.
- MUL with src1=0xFFFF_FFFF_FFFF_FFFF and src2=3 → 0xFFFF_FFFF_FFFF_FFFD, out_valid exactly 64 cycles after accept, in_ready=0 during the iterations. A rst pulse at cycle 20 of a second MUL → no out_valid.
- Opcode 0110111, and SLLI with imm[11:6]=000001 → out_valid=1, out_illegal=1, out_data=0. With MUL_EN=0, MUL → illegal.
- Backpressure: hold out_ready=0 for 3 cycles with ADD results pending → out_data stable and in_ready=0. Release with a new op on the same cycle → both transfers occur and no result is lost or duplicated.
